branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Registered, parametrised successor to the combinational jump decision logic.
- Resolves conditional jumps plus new CALL/RET opcodes, backed by a hardware return-address stack (RAS).
- Sits between decode and fetch. Accepts one branch-class instruction per valid/ready handshake and presents the next fetch address one cycle later on a registered output stage.

Parameters:
- WORD_SIZE, 16: address/instruction width; opcode is instruction[WORD_SIZE-1:WORD_SIZE-8].
- STACK_DEPTH, 8: RAS entries; power of two, at least 2.
- INSTR_STEP, 2: fall-through increment added to program_counter_address.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction/operands valid
- in_ready  output  1  unit can accept this cycle
- program_counter_address  input  WORD_SIZE  PC of the branch instruction
- instruction  input  WORD_SIZE  instruction word
- peek_jump_address  input  WORD_SIZE  target operand
- flags  input  8  Z=bit7, S=bit6, C=bit5, O=bit4; bits 3:0 ignored
- flush  input  1  discard pending output
- out_valid  output  1  new_address valid
- out_ready  input  1  fetch consumes result
- new_address  output  WORD_SIZE  next fetch address
- taken  output  1  result is a taken jump, CALL or RET
- stack_fault  output  1  RAS overflow/underflow on this result
- ras_count  output  clog2(STACK_DEPTH)+1  current RAS occupancy

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, new_address=0, taken=0, stack_fault=0.
  - RAS pointer=0, so ras_count=0.
  - RAS entry contents are don't-care.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - Result is registered on the accepting edge and visible the next cycle (latency 1).
  - Full throughput: one result per cycle when out_ready=1.
  - The output holds stable while out_valid && !out_ready.
- Fall-through address: seq = program_counter_address + INSTR_STEP, modulo 2^WORD_SIZE (wraps; e.g. 0xFFFF+2 = 0x0001).
- Opcodes (taken → peek_jump_address, otherwise → seq):
  - 0x14 JMP: always taken.
  - 0x15 JE: Z. 0x16 JNE: !Z.
  - 0x17 JC: C. 0x18 JNC: !C.
  - 0x19 JS: S. 0x1A JNS: !S.
  - 0x1B JO: O. 0x1C JNO: !O.
  - 0x1D JA: !C && !Z. 0x1E JAE: !C.
  - 0x1F JB: C. 0x20 JBE: C || Z.
  - 0x21 JG: !(S^O) && !Z. 0x22 JGE: !(S^O).
  - 0x23 JL: S^O. 0x24 JLE: (S^O) || Z.
  - 0x25 CALL:
    - RAS not full: push seq, new_address = peek_jump_address, taken=1.
    - RAS full: no push, new_address = seq, taken=0, stack_fault=1.
  - 0x26 RET:
    - RAS not empty: pop, new_address = popped entry, taken=1.
    - RAS empty: new_address = seq, taken=0, stack_fault=1.
  - Any other opcode: new_address = seq, taken=0, stack_fault=0.
- RAS:
  - LIFO, STACK_DEPTH entries, with a pointer 0..STACK_DEPTH.
  - Push/pop happens only on the accepting edge.
  - Stack contents are never altered by flush.
  - stack_fault is qualified by out_valid and describes only the current result.
- Flush:
  - flush=1 clears out_valid on the next edge and blocks acceptance that cycle; flush wins over a simultaneous accept.
  - RAS pointer and contents are unchanged.
  - A push/pop from a result already registered but not yet consumed is NOT rolled back.
- Reset mid-operation: immediate return to reset state; an in-flight result is lost.

Optional Feature:
- Macro: BRANCH_UNIT_STATS_EN.
- When defined, adds outputs branch_count[31:0] and taken_count[31:0]:
  - Both are async-reset to 0.
  - branch_count increments on every accepted opcode in 0x14..0x26.
  - taken_count increments on every accepted result with taken=1.
  - Both saturate at 0xFFFFFFFF and are unaffected by flush.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 → out_valid=0 and ras_count=0 immediately, without waiting for a clock.
- Conditional sweep at PC=0x0100, target=0x0400:
  - Drive each opcode 0x14..0x24 against all 16 Z/S/C/O combinations.
  - Check new_address is 0x0400 or 0x0102 per the condition table.
  - Include JA with C=1,Z=1 → 0x0102.
- CALL/RET nesting: CALL at 0x0010 (target 0x0200), then CALL at 0x0200 (target 0x0300), then RET, RET:
  - Expected new_address sequence: 0x0200, 0x0300, 0x0202, 0x0012.
  - Expected ras_count sequence: 1, 2, 1, 0.
- RAS boundaries (STACK_DEPTH=8):
  - A 9th CALL at PC=0x0050 → new_address=0x0052, stack_fault=1, ras_count stays 8.
  - RET with the RAS empty, PC=0xFFFF → new_address=0x0001, stack_fault=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0 and new_address stable throughout.
  - Releasing out_ready gives back-to-back results with no loss or duplication.
- Flush collision: assert flush together with in_valid on a CALL → input not accepted, out_valid=0 next cycle, ras_count unchanged. With BRANCH_UNIT_STATS_EN defined, branch_count is also unchanged.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: registered jump/CALL/RET resolver with a hardware return-address stack.
// Defining BRANCH_UNIT_STATS_EN adds saturating branch_count/taken_count outputs.
module branch_unit #(
  parameter int WORD_SIZE   = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INSTR_STEP  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_SIZE-1:0]         program_counter_address,
  input  logic [WORD_SIZE-1:0]         instruction,
  input  logic [WORD_SIZE-1:0]         peek_jump_address,
  input  logic [7:0]                   flags,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE-1:0]         new_address,
  output logic                         taken,
  output logic                         stack_fault,
  output logic [$clog2(STACK_DEPTH):0] ras_count
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]                  branch_count,
  output logic [31:0]                  taken_count
`endif
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(STACK_DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  typedef enum logic [7:0] {
    OP_JMP  = 8'h14, OP_JE  = 8'h15, OP_JNE = 8'h16, OP_JC  = 8'h17,
    OP_JNC  = 8'h18, OP_JS  = 8'h19, OP_JNS = 8'h1A, OP_JO  = 8'h1B,
    OP_JNO  = 8'h1C, OP_JA  = 8'h1D, OP_JAE = 8'h1E, OP_JB  = 8'h1F,
    OP_JBE  = 8'h20, OP_JG  = 8'h21, OP_JGE = 8'h22, OP_JL  = 8'h23,
    OP_JLE  = 8'h24, OP_CALL = 8'h25, OP_RET = 8'h26
  } opcode_e;

  logic [7:0]           opcode;
  logic                 z, s, c, o;
  logic [WORD_SIZE-1:0] seq;
  logic [PW-1:0]        ras_ptr;
  logic [WORD_SIZE-1:0] ras_mem [STACK_DEPTH];
  logic [AW-1:0]        top_idx;
  logic                 ras_full, ras_empty;
  logic                 accept;
  logic                 fault_q;
  logic [WORD_SIZE-1:0] nxt_addr;
  logic                 nxt_taken, nxt_fault, do_push, do_pop;
  logic                 unused_bits;

  assign opcode      = instruction[WORD_SIZE-1:WORD_SIZE-8];
  assign {z, s, c, o} = flags[7:4];
  assign unused_bits = ^{flags[3:0], instruction[WORD_SIZE-9:0]};
  assign seq         = program_counter_address + WORD_SIZE'(INSTR_STEP);

  assign ras_full  = (ras_ptr == PTR_FULL);
  assign ras_empty = (ras_ptr == '0);
  // Wraps correctly when the stack is full: the low bits are zero, minus one hits the top slot.
  assign top_idx   = ras_ptr[AW-1:0] - IDX_ONE;

  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign ras_count   = ras_ptr;
  assign stack_fault = out_valid && fault_q;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    nxt_taken = 1'b0;
    nxt_fault = 1'b0;
    nxt_addr  = seq;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    case (opcode)
      OP_JMP:  nxt_taken = 1'b1;
      OP_JE:   nxt_taken = z;
      OP_JNE:  nxt_taken = !z;
      OP_JC:   nxt_taken = c;
      OP_JNC:  nxt_taken = !c;
      OP_JS:   nxt_taken = s;
      OP_JNS:  nxt_taken = !s;
      OP_JO:   nxt_taken = o;
      OP_JNO:  nxt_taken = !o;
      OP_JA:   nxt_taken = !c && !z;
      OP_JAE:  nxt_taken = !c;
      OP_JB:   nxt_taken = c;
      OP_JBE:  nxt_taken = c || z;
      OP_JG:   nxt_taken = !(s ^ o) && !z;
      OP_JGE:  nxt_taken = !(s ^ o);
      OP_JL:   nxt_taken = s ^ o;
      OP_JLE:  nxt_taken = (s ^ o) || z;
      OP_CALL: begin
        do_push   = !ras_full;
        nxt_taken = !ras_full;
        nxt_fault = ras_full;
      end
      OP_RET: begin
        do_pop    = !ras_empty;
        nxt_fault = ras_empty;
      end
      default: ;
    endcase
    if (do_pop)
      nxt_addr = ras_mem[top_idx];
    else if (nxt_taken)
      nxt_addr = peek_jump_address;
    nxt_taken = nxt_taken || do_pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      new_address <= '0;
      taken       <= 1'b0;
      fault_q     <= 1'b0;
      ras_ptr     <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      new_address <= nxt_addr;
      taken       <= nxt_taken;
      fault_q     <= nxt_fault;
      if (do_push)
        ras_ptr <= ras_ptr + PTR_ONE;
      else if (do_pop)
        ras_ptr <= ras_ptr - PTR_ONE;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: stack storage has no reset; the pointer alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    if (accept && do_push)
      ras_mem[ras_ptr[AW-1:0]] <= seq;
  end

`ifdef BRANCH_UNIT_STATS_EN
  logic is_branch;
  assign is_branch = (opcode >= OP_JMP) && (opcode <= OP_RET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (accept) begin
      if (is_branch && branch_count != '1)
        branch_count <= branch_count + 32'd1;
      if (nxt_taken && taken_count != '1)
        taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed scenarios plus random traffic against a
// queue-based reference model of the jump table, handshake and return-address stack.
module tb_branch_unit;

  localparam int W = 16;
  localparam int D = 8;
  localparam int STEP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] pc = '0;
  logic [W-1:0] instr = '0;
  logic [W-1:0] tgt = '0;
  logic [7:0]   flags = '0;
  logic         in_ready, out_valid, taken, stack_fault;
  logic [W-1:0] new_address;
  logic [3:0]   ras_count;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0]  branch_count, taken_count;
`endif

  branch_unit #(.WORD_SIZE(W), .STACK_DEPTH(D), .INSTR_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .program_counter_address(pc), .instruction(instr), .peek_jump_address(tgt),
    .flags(flags), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .new_address(new_address), .taken(taken), .stack_fault(stack_fault),
    .ras_count(ras_count)
`ifdef BRANCH_UNIT_STATS_EN
    , .branch_count(branch_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Reference model state
  bit           m_valid;
  logic [W-1:0] m_addr;
  bit           m_taken, m_fault;
  logic [W-1:0] ras_q[$];
  int unsigned  m_branches, m_takens;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_taken(input logic [7:0] op, input logic [7:0] fl);
    bit z, s, c, o;
    z = fl[7]; s = fl[6]; c = fl[5]; o = fl[4];
    case (op)
      8'h14: return 1'b1;
      8'h15: return z;
      8'h16: return !z;
      8'h17: return c;
      8'h18: return !c;
      8'h19: return s;
      8'h1A: return !s;
      8'h1B: return o;
      8'h1C: return !o;
      8'h1D: return !c && !z;
      8'h1E: return !c;
      8'h1F: return c;
      8'h20: return c || z;
      8'h21: return (s == o) && !z;
      8'h22: return s == o;
      8'h23: return s != o;
      8'h24: return (s != o) || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_accept();
    logic [7:0]   op;
    logic [W-1:0] seq;
    op  = instr[W-1:W-8];
    seq = pc + W'(STEP);
    m_valid = 1'b1;
    m_addr  = seq;
    m_taken = 1'b0;
    m_fault = 1'b0;
    if (op >= 8'h14 && op <= 8'h24) begin
      if (cond_taken(op, flags)) begin
        m_taken = 1'b1;
        m_addr  = tgt;
      end
    end else if (op == 8'h25) begin
      if (ras_q.size() < D) begin
        ras_q.push_back(seq);
        m_taken = 1'b1;
        m_addr  = tgt;
      end else m_fault = 1'b1;
    end else if (op == 8'h26) begin
      if (ras_q.size() > 0) begin
        m_addr  = ras_q.pop_back();
        m_taken = 1'b1;
      end else m_fault = 1'b1;
    end
    if (op >= 8'h14 && op <= 8'h26 && m_branches != 32'hFFFF_FFFF) m_branches++;
    if (m_taken && m_takens != 32'hFFFF_FFFF) m_takens++;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_taken = 1'b0;
    m_fault = 1'b0;
    ras_q.delete();
    m_branches = 0;
    m_takens   = 0;
  endtask

  // One clock: predict, advance past the edge, compare every visible output.
  task automatic tick(input string tag);
    bit exp_ready;
    #1;
    exp_ready = !flush && (!m_valid || out_ready);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    if (in_valid && exp_ready) model_accept();
    else if (flush || out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".ras_count"}, 32'(ras_count), 32'(ras_q.size()));
    check({tag, ".stack_fault"}, 32'(stack_fault), 32'(m_valid && m_fault));
    if (m_valid) begin
      check({tag, ".new_address"}, 32'(new_address), 32'(m_addr));
      check({tag, ".taken"}, 32'(taken), 32'(m_taken));
    end
`ifdef BRANCH_UNIT_STATS_EN
    check({tag, ".branch_count"}, branch_count, m_branches);
    check({tag, ".taken_count"}, taken_count, m_takens);
`endif
  endtask

  task automatic drive(input logic [7:0] op, input logic [W-1:0] p, input logic [W-1:0] t,
                       input logic [3:0] zsco);
    in_valid = 1'b1;
    instr    = {op, 8'($urandom)};
    pc       = p;
    tgt      = t;
    flags    = {zsco, 4'($urandom)};
  endtask

  initial begin
    logic [W-1:0] held;
    model_reset();

    // Reset state
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.new_address", 32'(new_address), 32'd0);
    check("rst.taken", 32'(taken), 32'd0);
    check("rst.stack_fault", 32'(stack_fault), 32'd0);
    check("rst.ras_count", 32'(ras_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-stream with a valid result and a pushed entry
    out_ready = 1'b1;
    drive(8'h25, 16'h0010, 16'h0200, 4'h0);
    tick("pre_rst");
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.ras_count", 32'(ras_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Conditional sweep
    for (int op = 8'h14; op <= 8'h24; op++) begin
      for (int f = 0; f < 16; f++) begin
        drive(8'(op), 16'h0100, 16'h0400, 4'(f));
        tick("sweep");
        if (op == 8'h1D && f[3] && f[1])
          check("ja_cz.new_address", 32'(new_address), 32'h0102);
      end
    end

    // CALL/RET nesting
    drive(8'h25, 16'h0010, 16'h0200, 4'h0); tick("nest0");
    check("nest0.addr", 32'(new_address), 32'h0200);
    check("nest0.cnt", 32'(ras_count), 32'd1);
    drive(8'h25, 16'h0200, 16'h0300, 4'h0); tick("nest1");
    check("nest1.addr", 32'(new_address), 32'h0300);
    check("nest1.cnt", 32'(ras_count), 32'd2);
    drive(8'h26, 16'h0300, 16'h0999, 4'h0); tick("nest2");
    check("nest2.addr", 32'(new_address), 32'h0202);
    check("nest2.cnt", 32'(ras_count), 32'd1);
    drive(8'h26, 16'h0202, 16'h0999, 4'h0); tick("nest3");
    check("nest3.addr", 32'(new_address), 32'h0012);
    check("nest3.cnt", 32'(ras_count), 32'd0);

    // RAS boundaries: fill, overflow, drain, underflow
    for (int i = 0; i < D; i++) begin
      drive(8'h25, 16'(i * 16), 16'($urandom), 4'($urandom));
      tick("fill");
    end
    drive(8'h25, 16'h0050, 16'h0777, 4'h0); tick("ovf");
    check("ovf.addr", 32'(new_address), 32'h0052);
    check("ovf.fault", 32'(stack_fault), 32'd1);
    check("ovf.cnt", 32'(ras_count), 32'd8);
    for (int i = 0; i < D; i++) begin
      drive(8'h26, 16'($urandom), 16'($urandom), 4'($urandom));
      tick("drain");
    end
    drive(8'h26, 16'hFFFF, 16'h0777, 4'h0); tick("udf");
    check("udf.addr", 32'(new_address), 32'h0001);
    check("udf.fault", 32'(stack_fault), 32'd1);
    check("udf.taken", 32'(taken), 32'd0);

    // Flush collision with a CALL
    drive(8'h25, 16'h0020, 16'h0500, 4'h0); tick("fl_pre");
    flush = 1'b1;
    drive(8'h25, 16'h0500, 16'h0600, 4'h0); tick("flush");
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.cnt", 32'(ras_count), 32'd1);
    flush = 1'b0;

    // Backpressure then release
    drive(8'h14, 16'h1000, 16'h2000, 4'h0); tick("bp0");
    held = new_address;
    out_ready = 1'b0;
    drive(8'h14, 16'h1002, 16'h3000, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick("bp_hold");
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.stable", 32'(new_address), 32'(held));
    end
    out_ready = 1'b1;
    tick("bp_rel0");
    check("bp_rel0.addr", 32'(new_address), 32'h3000);
    drive(8'h14, 16'h3000, 16'h4000, 4'h0); tick("bp_rel1");
    check("bp_rel1.addr", 32'(new_address), 32'h4000);
    in_valid = 1'b0;
    tick("bp_drain");

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(8'h14, 8'h26));
      drive(op, 16'($urandom), 16'($urandom), 4'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
